// File: rtl/hit_resolver.sv
// hit_resolver: per-frame hit arbitration for a two-player fighting game.
// Accepts hits, applies damage and hitstun, and tracks the FIGHT/KO round flow.
// All outputs come straight from registers updated on frame_tick cycles.
module hit_resolver #(
    parameter logic [7:0] MAX_HEALTH  = 8'd100,
    parameter logic [7:0] DAMAGE      = 8'd10,
    parameter logic [5:0] STUN_FRAMES = 6'd30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic [1:0] hitresult,
    input  logic [3:0] p1_state,
    input  logic [3:0] p2_state,
    input  logic       restart,
    output logic [7:0] p1_health,
    output logic [7:0] p2_health,
    output logic       p1_stunned,
    output logic       p2_stunned,
    output logic       p1_hit_pulse,
    output logic       p2_hit_pulse,
    output logic       game_over,
    output logic [1:0] winner
);

    typedef enum logic {
        FIGHT = 1'b0,
        KO    = 1'b1
    } state_e;

    state_e     state_q, state_d;

    logic [7:0] p1_health_q, p1_health_d;
    logic [7:0] p2_health_q, p2_health_d;
    logic [5:0] p1_stun_q, p1_stun_d;
    logic [5:0] p2_stun_q, p2_stun_d;
    logic       p1_stunned_q, p1_stunned_d;
    logic       p2_stunned_q, p2_stunned_d;
    logic       p1_consumed_q, p1_consumed_d;
    logic       p2_consumed_q, p2_consumed_d;
    logic       p1_hit_pulse_q, p1_hit_pulse_d;
    logic       p2_hit_pulse_q, p2_hit_pulse_d;
    logic       game_over_q, game_over_d;
    logic [1:0] winner_q, winner_d;

    // Accepted-hit strobes for the current frame (P1 lands on P2, P2 lands on P1)
    logic       p1_lands;
    logic       p2_lands;

    // Attack start, attack end and attack pull are the states that belong to one swing
    function automatic logic is_attacking(input logic [3:0] st);
        return (st == 4'd3) || (st == 4'd4) || (st == 4'd5);
    endfunction

    // Health never wraps: a hit bigger than what is left just empties the bar
    function automatic logic [7:0] take_damage(input logic [7:0] h);
        return (h > DAMAGE) ? (h - DAMAGE) : 8'd0;
    endfunction

    // Counting hitstun down by one frame, holding at zero
    function automatic logic [5:0] stun_tick(input logic [5:0] s);
        return (s != 6'd0) ? (s - 6'd1) : 6'd0;
    endfunction

    // Round FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FIGHT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-frame game update; nothing moves unless frame_tick is high
    always_comb begin
        state_d        = state_q;
        p1_health_d    = p1_health_q;
        p2_health_d    = p2_health_q;
        p1_stun_d      = p1_stun_q;
        p2_stun_d      = p2_stun_q;
        p1_consumed_d  = p1_consumed_q;
        p2_consumed_d  = p2_consumed_q;
        p1_hit_pulse_d = 1'b0;
        p2_hit_pulse_d = 1'b0;
        game_over_d    = game_over_q;
        winner_d       = winner_q;
        p1_lands       = 1'b0;
        p2_lands       = 1'b0;

        if (frame_tick) begin
            case (state_q)
                FIGHT: begin
                    // A hit only counts once per swing and never on a victim already in hitstun
                    p1_lands = hitresult[1] && !p1_consumed_q && (p2_stun_q == 6'd0);
                    p2_lands = hitresult[0] && !p2_consumed_q && (p1_stun_q == 6'd0);

                    if (p1_lands) begin
                        p2_health_d = take_damage(p2_health_q);
                        p2_stun_d   = STUN_FRAMES;
                    end else begin
                        p2_stun_d   = stun_tick(p2_stun_q);
                    end

                    if (p2_lands) begin
                        p1_health_d = take_damage(p1_health_q);
                        p1_stun_d   = STUN_FRAMES;
                    end else begin
                        p1_stun_d   = stun_tick(p1_stun_q);
                    end

                    // Leaving the attack states re-arms the attacker for the next swing
                    if (!is_attacking(p1_state)) begin
                        p1_consumed_d = 1'b0;
                    end else if (p1_lands) begin
                        p1_consumed_d = 1'b1;
                    end

                    if (!is_attacking(p2_state)) begin
                        p2_consumed_d = 1'b0;
                    end else if (p2_lands) begin
                        p2_consumed_d = 1'b1;
                    end

                    p2_hit_pulse_d = p1_lands;
                    p1_hit_pulse_d = p2_lands;

                    // Either bar emptying ends the round; both emptying together is a draw
                    if ((p1_health_d == 8'd0) || (p2_health_d == 8'd0)) begin
                        state_d     = KO;
                        game_over_d = 1'b1;
                        winner_d    = {(p1_health_d == 8'd0), (p2_health_d == 8'd0)};
                    end
                end

                KO: begin
                    if (restart) begin
                        state_d       = FIGHT;
                        p1_health_d   = MAX_HEALTH;
                        p2_health_d   = MAX_HEALTH;
                        p1_stun_d     = 6'd0;
                        p2_stun_d     = 6'd0;
                        p1_consumed_d = 1'b0;
                        p2_consumed_d = 1'b0;
                        game_over_d   = 1'b0;
                        winner_d      = 2'b00;
                    end else begin
                        // Health and winner stay frozen; stun animations still run out
                        p1_stun_d = stun_tick(p1_stun_q);
                        p2_stun_d = stun_tick(p2_stun_q);
                        if (!is_attacking(p1_state)) begin
                            p1_consumed_d = 1'b0;
                        end
                        if (!is_attacking(p2_state)) begin
                            p2_consumed_d = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d = FIGHT;
                end
            endcase
        end

        p1_stunned_d = (p1_stun_d != 6'd0);
        p2_stunned_d = (p2_stun_d != 6'd0);
    end

    // Round data registers; reset discards everything mid-round
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1_health_q    <= MAX_HEALTH;
            p2_health_q    <= MAX_HEALTH;
            p1_stun_q      <= 6'd0;
            p2_stun_q      <= 6'd0;
            p1_stunned_q   <= 1'b0;
            p2_stunned_q   <= 1'b0;
            p1_consumed_q  <= 1'b0;
            p2_consumed_q  <= 1'b0;
            p1_hit_pulse_q <= 1'b0;
            p2_hit_pulse_q <= 1'b0;
            game_over_q    <= 1'b0;
            winner_q       <= 2'b00;
        end else begin
            p1_health_q    <= p1_health_d;
            p2_health_q    <= p2_health_d;
            p1_stun_q      <= p1_stun_d;
            p2_stun_q      <= p2_stun_d;
            p1_stunned_q   <= p1_stunned_d;
            p2_stunned_q   <= p2_stunned_d;
            p1_consumed_q  <= p1_consumed_d;
            p2_consumed_q  <= p2_consumed_d;
            p1_hit_pulse_q <= p1_hit_pulse_d;
            p2_hit_pulse_q <= p2_hit_pulse_d;
            game_over_q    <= game_over_d;
            winner_q       <= winner_d;
        end
    end

    assign p1_health    = p1_health_q;
    assign p2_health    = p2_health_q;
    assign p1_stunned   = p1_stunned_q;
    assign p2_stunned   = p2_stunned_q;
    assign p1_hit_pulse = p1_hit_pulse_q;
    assign p2_hit_pulse = p2_hit_pulse_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_hit_resolver.sv
// tb_hit_resolver: directed scenarios plus a randomized run against a
// frame-level model of the game rules. A second instance with a small
// starting health exercises the damage saturation and early KO paths.
module tb_hit_resolver;

    localparam int MAXH = 100;
    localparam int DMG  = 10;
    localparam int STUN = 30;

    logic       clk;
    logic       rst;
    logic       frame_tick;
    logic [1:0] hitresult;
    logic [3:0] p1_state;
    logic [3:0] p2_state;
    logic       restart;

    logic [7:0] p1_health, p2_health;
    logic       p1_stunned, p2_stunned;
    logic       p1_hit_pulse, p2_hit_pulse;
    logic       game_over;
    logic [1:0] winner;

    logic [7:0] s_p1_health, s_p2_health;
    logic       s_p1_stunned, s_p2_stunned;
    logic       s_p1_hit_pulse, s_p2_hit_pulse;
    logic       s_game_over;
    logic [1:0] s_winner;

    int n_cmp;
    int n_fail;

    // Frame-level model of the main instance
    int m_h1, m_h2, m_st1, m_st2, m_win;
    bit m_c1, m_c2, m_pu1, m_pu2, m_ko;

    hit_resolver dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .hitresult(hitresult),
        .p1_state(p1_state), .p2_state(p2_state), .restart(restart),
        .p1_health(p1_health), .p2_health(p2_health),
        .p1_stunned(p1_stunned), .p2_stunned(p2_stunned),
        .p1_hit_pulse(p1_hit_pulse), .p2_hit_pulse(p2_hit_pulse),
        .game_over(game_over), .winner(winner)
    );

    hit_resolver #(.MAX_HEALTH(8'd25), .DAMAGE(8'd10), .STUN_FRAMES(6'd30)) dut_sat (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .hitresult(hitresult),
        .p1_state(p1_state), .p2_state(p2_state), .restart(restart),
        .p1_health(s_p1_health), .p2_health(s_p2_health),
        .p1_stunned(s_p1_stunned), .p2_stunned(s_p2_stunned),
        .p1_hit_pulse(s_p1_hit_pulse), .p2_hit_pulse(s_p2_hit_pulse),
        .game_over(s_game_over), .winner(s_winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_h1 = MAXH; m_h2 = MAXH; m_st1 = 0; m_st2 = 0;
        m_c1 = 0; m_c2 = 0; m_pu1 = 0; m_pu2 = 0; m_ko = 0; m_win = 0;
    endtask

    task automatic model_tick(input logic [1:0] hr, input logic [3:0] s1, input logic [3:0] s2, input logic rs);
        bit a1, a2, atk1, atk2;
        atk1 = (s1 >= 3) && (s1 <= 5);
        atk2 = (s2 >= 3) && (s2 <= 5);
        m_pu1 = 0;
        m_pu2 = 0;
        if (!m_ko) begin
            a1 = hr[1] && !m_c1 && (m_st2 == 0);
            a2 = hr[0] && !m_c2 && (m_st1 == 0);
            m_st2 = a1 ? STUN : ((m_st2 > 0) ? m_st2 - 1 : 0);
            m_st1 = a2 ? STUN : ((m_st1 > 0) ? m_st1 - 1 : 0);
            if (a1) begin m_h2 = m_h2 - DMG; if (m_h2 < 0) m_h2 = 0; end
            if (a2) begin m_h1 = m_h1 - DMG; if (m_h1 < 0) m_h1 = 0; end
            m_c1 = atk1 ? (m_c1 || a1) : 0;
            m_c2 = atk2 ? (m_c2 || a2) : 0;
            m_pu2 = a1;
            m_pu1 = a2;
            if (m_h1 == 0 || m_h2 == 0) begin
                m_ko  = 1;
                m_win = ((m_h1 == 0) ? 2 : 0) + ((m_h2 == 0) ? 1 : 0);
            end
        end else if (rs) begin
            model_reset();
        end else begin
            if (m_st1 > 0) m_st1 = m_st1 - 1;
            if (m_st2 > 0) m_st2 = m_st2 - 1;
            if (!atk1) m_c1 = 0;
            if (!atk2) m_c2 = 0;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        frame_tick = 1'b0;
        hitresult = 2'b00;
        p1_state = 4'd0;
        p2_state = 4'd0;
        restart = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Called at a negedge; returns at the next negedge with the frame's results visible
    task automatic do_frame(input logic [1:0] hr, input logic [3:0] s1, input logic [3:0] s2, input logic rs);
        hitresult = hr;
        p1_state = s1;
        p2_state = s2;
        restart = rs;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        model_tick(hr, s1, s2, rs);
    endtask

    task automatic idle_cycle();
        hitresult = 2'($urandom);
        p1_state = 4'($urandom_range(0, 7));
        p2_state = 4'($urandom_range(0, 7));
        restart = 1'($urandom);
        frame_tick = 1'b0;
        @(negedge clk);
        m_pu1 = 0;
        m_pu2 = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({p1_health, p2_health, p1_stunned, p2_stunned, p1_hit_pulse, p2_hit_pulse, game_over, winner}
            !== {8'd100, 8'd100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL reset_main: got h=%0d/%0d st=%b%b pu=%b%b go=%b w=%b expected 100/100 all zero",
                     p1_health, p2_health, p1_stunned, p2_stunned, p1_hit_pulse, p2_hit_pulse, game_over, winner);
        end
        n_cmp++;
        if ({s_p1_health, s_p2_health, s_game_over, s_winner} !== {8'd25, 8'd25, 1'b0, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL reset_sat: got h=%0d/%0d go=%b w=%b expected 25/25 go=0 w=00",
                     s_p1_health, s_p2_health, s_game_over, s_winner);
        end
    endtask

    task automatic test_single_hit();
        apply_reset();
        do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        n_cmp++;
        if ({p2_health, p2_stunned, p2_hit_pulse, p1_health, p1_hit_pulse} !== {8'd90, 1'b1, 1'b1, 8'd100, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL single_hit: got p2h=%0d st=%b pu=%b p1h=%0d p1pu=%b expected 90 1 1 100 0",
                     p2_health, p2_stunned, p2_hit_pulse, p1_health, p1_hit_pulse);
        end
        @(negedge clk);
        n_cmp++;
        if ({p2_hit_pulse, p2_health} !== {1'b0, 8'd90}) begin
            n_fail++;
            $display("[TB] FAIL single_hit_pulse_width: got pu=%b p2h=%0d expected pu=0 p2h=90", p2_hit_pulse, p2_health);
        end
        do_frame(2'b00, 4'd0, 4'd0, 1'b1);
        n_cmp++;
        if ({p2_health, game_over} !== {8'd90, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL restart_in_fight: got p2h=%0d go=%b expected 90 0", p2_health, game_over);
        end
    endtask

    task automatic test_one_hit_per_attack();
        apply_reset();
        repeat (5) do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        n_cmp++;
        if (p2_health !== 8'd90) begin
            n_fail++;
            $display("[TB] FAIL held_attack_once: got p2h=%0d expected 90", p2_health);
        end
        repeat (26) do_frame(2'b00, 4'd4, 4'd0, 1'b0);
        n_cmp++;
        if (p2_stunned !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL held_attack_stun_expired: got %b expected 0", p2_stunned);
        end
        do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        n_cmp++;
        if (p2_health !== 8'd90) begin
            n_fail++;
            $display("[TB] FAIL consumed_blocks: got p2h=%0d expected 90", p2_health);
        end
        do_frame(2'b10, 4'd0, 4'd0, 1'b0);
        do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        n_cmp++;
        if (p2_health !== 8'd80) begin
            n_fail++;
            $display("[TB] FAIL new_attack_hits: got p2h=%0d expected 80", p2_health);
        end
    endtask

    task automatic test_stun_window();
        int bad;
        apply_reset();
        do_frame(2'b10, 4'd3, 4'd0, 1'b0);
        bad = 0;
        for (int i = 1; i <= 29; i++) begin
            do_frame(2'b10, (i % 2) ? 4'd4 : 4'd0, 4'd0, 1'b0);
            if (p2_stunned !== 1'b1 || p2_health !== 8'd90) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("[TB] FAIL stun_window: %0d of 29 frames wrong, required stunned with p2h=90 throughout", bad);
        end
        do_frame(2'b00, 4'd0, 4'd0, 1'b0);
        n_cmp++;
        if ({p2_stunned, p2_health} !== {1'b0, 8'd90}) begin
            n_fail++;
            $display("[TB] FAIL stun_expiry_at_30: got st=%b p2h=%0d expected 0 90", p2_stunned, p2_health);
        end
        do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        n_cmp++;
        if (p2_health !== 8'd80) begin
            n_fail++;
            $display("[TB] FAIL hit_after_stun: got p2h=%0d expected 80", p2_health);
        end
    endtask

    task automatic test_double_ko();
        apply_reset();
        repeat (9) begin
            do_frame(2'b11, 4'd4, 4'd4, 1'b0);
            repeat (30) do_frame(2'b00, 4'd0, 4'd0, 1'b0);
        end
        n_cmp++;
        if ({p1_health, p2_health, game_over} !== {8'd10, 8'd10, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL double_ko_setup: got %0d/%0d go=%b expected 10/10 go=0", p1_health, p2_health, game_over);
        end
        do_frame(2'b11, 4'd4, 4'd4, 1'b0);
        n_cmp++;
        if ({p1_health, p2_health, game_over, winner, p1_hit_pulse, p2_hit_pulse} !== {8'd0, 8'd0, 1'b1, 2'b11, 1'b1, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL double_ko: got %0d/%0d go=%b w=%b pu=%b%b expected 0/0 go=1 w=11 pu=11",
                     p1_health, p2_health, game_over, winner, p1_hit_pulse, p2_hit_pulse);
        end
        repeat (30) do_frame(2'b11, 4'd4, 4'd4, 1'b0);
        n_cmp++;
        if ({p1_stunned, p2_stunned, game_over, winner, p1_hit_pulse, p2_hit_pulse} !== {1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL ko_hold: got st=%b%b go=%b w=%b pu=%b%b expected st=00 go=1 w=11 pu=00",
                     p1_stunned, p2_stunned, game_over, winner, p1_hit_pulse, p2_hit_pulse);
        end
        do_frame(2'b00, 4'd0, 4'd0, 1'b1);
        n_cmp++;
        if ({p1_health, p2_health, game_over, winner} !== {8'd100, 8'd100, 1'b0, 2'b00}) begin
            n_fail++;
            $display("[TB] FAIL restart_main: got %0d/%0d go=%b w=%b expected 100/100 go=0 w=00",
                     p1_health, p2_health, game_over, winner);
        end
    endtask

    task automatic test_saturate_restart();
        apply_reset();
        do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        repeat (30) do_frame(2'b00, 4'd0, 4'd0, 1'b0);
        do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        repeat (30) do_frame(2'b00, 4'd0, 4'd0, 1'b0);
        n_cmp++;
        if (s_p2_health !== 8'd5) begin
            n_fail++;
            $display("[TB] FAIL sat_setup: got p2h=%0d expected 5", s_p2_health);
        end
        do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        n_cmp++;
        if ({s_p2_health, s_p1_health, s_game_over, s_winner} !== {8'd0, 8'd25, 1'b1, 2'b01}) begin
            n_fail++;
            $display("[TB] FAIL saturate_ko: got p2h=%0d p1h=%0d go=%b w=%b expected 0 25 1 01",
                     s_p2_health, s_p1_health, s_game_over, s_winner);
        end
        do_frame(2'b00, 4'd0, 4'd0, 1'b1);
        n_cmp++;
        if ({s_p1_health, s_p2_health, s_game_over, s_winner, s_p2_stunned} !== {8'd25, 8'd25, 1'b0, 2'b00, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL restart_sat: got %0d/%0d go=%b w=%b st=%b expected 25/25 go=0 w=00 st=0",
                     s_p1_health, s_p2_health, s_game_over, s_winner, s_p2_stunned);
        end
    endtask

    task automatic test_async_reset_ko();
        apply_reset();
        do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        repeat (30) do_frame(2'b00, 4'd0, 4'd0, 1'b0);
        do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        repeat (30) do_frame(2'b00, 4'd0, 4'd0, 1'b0);
        do_frame(2'b10, 4'd4, 4'd0, 1'b0);
        n_cmp++;
        if ({s_game_over, p2_stunned} !== {1'b1, 1'b1}) begin
            n_fail++;
            $display("[TB] FAIL async_setup: got sat go=%b main st=%b expected 1 1", s_game_over, p2_stunned);
        end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({s_p1_health, s_p2_health, s_game_over, s_winner, s_p2_stunned} !== {8'd25, 8'd25, 1'b0, 2'b00, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL async_reset_sat: got %0d/%0d go=%b w=%b st=%b expected 25/25 0 00 0",
                     s_p1_health, s_p2_health, s_game_over, s_winner, s_p2_stunned);
        end
        n_cmp++;
        if ({p2_health, p2_stunned, p2_hit_pulse} !== {8'd100, 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL async_reset_main: got p2h=%0d st=%b pu=%b expected 100 0 0", p2_health, p2_stunned, p2_hit_pulse);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        logic [22:0] got, exp;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                do_frame(2'($urandom), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                         ($urandom_range(0, 3) == 0));
            end
            got = {p1_health, p2_health, p1_stunned, p2_stunned, p1_hit_pulse, p2_hit_pulse, game_over, winner};
            exp = {8'(m_h1), 8'(m_h2), (m_st1 != 0), (m_st2 != 0), m_pu1, m_pu2, m_ko, 2'(m_win)};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("[TB] FAIL random_step%0d: got h=%0d/%0d st=%b%b pu=%b%b go=%b w=%b expected h=%0d/%0d st=%b%b pu=%b%b go=%b w=%b",
                         i, got[22:15], got[14:7], got[6], got[5], got[4], got[3], got[2], got[1:0],
                         exp[22:15], exp[14:7], exp[6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
            end
        end
    endtask

    // Guard against a stalled run
    initial begin
        #2000000;
        n_fail++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b1;
        frame_tick = 1'b0;
        hitresult = 2'b00;
        p1_state = 4'd0;
        p2_state = 4'd0;
        restart = 1'b0;
        model_reset();
        test_reset();
        test_single_hit();
        test_one_hit_per_attack();
        test_stun_window();
        test_double_ko();
        test_saturate_restart();
        test_async_reset_ko();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hit_resolver.md
HIT_RESOLVER -- requirements
Module: hit_resolver

Interface
REQ-001 SHALL have parameter MAX_HEALTH, default 8'd100, starting health per player.
REQ-002 SHALL have parameter DAMAGE, default 8'd10, health removed per accepted hit.
REQ-003 SHALL have parameter STUN_FRAMES, default 6'd30, hitstun length in frames.
REQ-004 SHALL have port clk  input  1  system clock, the only clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse per video frame; all game updates occur only on it.
REQ-007 SHALL have port hitresult  input  2  hit detector output; bit1 = P1 hits P2, bit0 = P2 hits P1.
REQ-008 SHALL have port p1_state  input  4  P1 FSM state (0 idle, 1 fwd, 2 back, 3 atk start, 4 atk end, 5 atk pull).
REQ-009 SHALL have port p2_state  input  4  P2 FSM state, same encoding.
REQ-010 SHALL have port restart  input  1  level request to start a new round.
REQ-011 SHALL have port p1_health  output  8  P1 remaining health.
REQ-012 SHALL have port p2_health  output  8  P2 remaining health.
REQ-013 SHALL have port p1_stunned  output  1  P1 in hitstun.
REQ-014 SHALL have port p2_stunned  output  1  P2 in hitstun.
REQ-015 SHALL have port p1_hit_pulse  output  1  one-cycle pulse: P1 took an accepted hit.
REQ-016 SHALL have port p2_hit_pulse  output  1  one-cycle pulse: P2 took an accepted hit.
REQ-017 SHALL have port game_over  output  1  high while in KO state.
REQ-018 SHALL have port winner  output  2  00 none, 01 P1 won, 10 P2 won, 11 draw.

Function
REQ-019 SHALL implement FSM states FIGHT and KO; all outputs registered.
REQ-020 SHALL, in FIGHT on frame_tick, evaluate hitresult; no state/health/stun change on cycles without frame_tick.
REQ-021 SHALL accept a P1-on-P2 hit when hitresult[1]=1, p1_consumed=0, p2 stun counter=0; same symmetric rule for P2-on-P1 via bit0.
REQ-022 SHALL set p1_consumed on an accepted P1 hit and clear it on any frame_tick where p1_state is not 3, 4 or 5 (one hit per attack); p2_consumed symmetric.
REQ-023 SHALL, on accepted hit, subtract DAMAGE from victim health saturating at 0 (never wrap), load victim stun counter with STUN_FRAMES, pulse victim hit_pulse in the following cycle.
REQ-024 SHALL decrement a nonzero stun counter by 1 per frame_tick; load takes priority over decrement; pN_stunned = (counter != 0).
REQ-025 SHALL process hitresult=2'b11 with both accepted as two independent hits in the same frame.
REQ-026 SHALL transition FIGHT->KO on the frame where either health becomes 0; winner = 01 if only P2 at 0, 10 if only P1 at 0, 11 if both.
REQ-027 SHALL, in KO, ignore hitresult, freeze health and winner, keep game_over=1, continue decrementing stun counters to 0.
REQ-028 SHALL transition KO->FIGHT on a frame_tick with restart=1: health=MAX_HEALTH, stun counters=0, consumed flags=0, winner=00, game_over=0.
REQ-029 SHALL ignore restart while in FIGHT.
REQ-030 SHALL be a single-cycle update: registered outputs reflect a frame_tick decision on the next clk edge.

Reset
REQ-031 SHALL on rst=1, asynchronously: FSM=FIGHT, p1_health=p2_health=MAX_HEALTH, stun counters=0, consumed flags=0, hit pulses=0, game_over=0, winner=00.
REQ-032 SHALL, if rst asserts mid-KO or mid-stun, discard all round state and resume per REQ-031 after release.

Verification
REQ-033 SHALL verify: rst, then hitresult=10, p1_state=4, one frame_tick -> p2_health=90, p2_stunned=1, p2_hit_pulse one cycle.
REQ-034 SHALL verify: hitresult=10 held 5 frames with p1_state=4 -> p2_health=90 only; p1_state=0 for 1 frame, then 4, with p2 stun expired -> p2_health=80.
REQ-035 SHALL verify: hit lands at frame 0 -> p2_stunned drops exactly after 30 frame_ticks; hits on P2 inside window ignored.
REQ-036 SHALL verify: both health=10, hitresult=11 on one frame -> both 0, game_over=1, winner=11.
REQ-037 SHALL verify: p2_health=5, DAMAGE=10 hit -> p2_health=0 (no wrap), winner=01; restart=1 on next frame_tick -> health 100/100, winner=00.
REQ-038 SHALL verify: rst pulse asserted asynchronously between clk edges during KO -> outputs at reset values immediately.
